// File: rtl/instr_fetch.sv
// Instruction fetch: PC handshake, one in-flight memory read, circular prefetch queue.
// Optional build macro FETCH_STATS_EN adds fetch/flush counters with $display tracing.
module instr_fetch #(
  parameter int WORD  = 16,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            pc_fetch,
  input  logic [WORD-1:0] pc_location,
  output logic            pc_step,
  input  logic            redirect,
  output logic            mem_req,
  output logic [WORD-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [WORD-1:0] mem_rdata,
  output logic            instr_valid,
  output logic [WORD-1:0] instr,
  output logic [WORD-1:0] instr_pc,
  input  logic            instr_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOC, MEM, DRAIN} state_t;

  state_t                     state_q;
  logic                       mem_req_q;
  logic [WORD-1:0]            addr_q;
  logic [DEPTH-1:0][WORD-1:0] data_q, pc_q;
  logic [AW-1:0]              rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]              count_q;
  logic                       full, push, pop;

  assign full = (count_q == CW'(DEPTH));
  // Gated by rst_n so the pulse stays low while reset is held.
  assign pc_fetch = rst_n && (state_q == IDLE) && !full && !redirect;
  assign push     = (state_q == MEM) && mem_ack && !redirect;
  assign pc_step  = push;
  assign pop      = (count_q != '0) && instr_ready && !redirect;

  assign mem_req     = mem_req_q;
  assign mem_addr    = addr_q;
  assign instr_valid = (count_q != '0);
  assign instr       = data_q[rd_ptr_q];
  assign instr_pc    = pc_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (pc_fetch) state_q <= LOC;
        LOC: begin
          if (redirect) state_q <= IDLE;
          else begin
            addr_q    <= pc_location;
            mem_req_q <= 1'b1;
            state_q   <= MEM;
          end
        end
        MEM: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end else if (redirect) state_q <= DRAIN;
        end
        // A request is never withdrawn: wait out the ack and drop the word.
        DRAIN: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      pc_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= mem_rdata;
        pc_q[wr_ptr_q]   <= addr_q;
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic [WORD-1:0] fetch_count_q, flush_count_q;

  // A flush counts only when it actually discards something.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (push) begin
        fetch_count_q <= fetch_count_q + WORD'(1);
        $display("instr_fetch: push addr=%h word=%h", addr_q, mem_rdata);
      end
      if (redirect && ((count_q != '0) || (state_q == MEM))) begin
        flush_count_q <= flush_count_q + WORD'(1);
        $display("instr_fetch: flush count=%0d", count_q);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: PC and memory models, scoreboard on the decode side.
module tb_instr_fetch;
  localparam logic [15:0] KEY = 16'hA5B5;

  logic        clk, rst_n, pc_fetch, pc_step, redirect, mem_req, mem_ack;
  logic        instr_valid, instr_ready, ack_block;
  logic [15:0] pc_location, mem_addr, mem_rdata, instr, instr_pc;
  logic [15:0] jump_tgt, start_pc, pc_model;
  int          ack_wait, wcnt;
  int          n_chk, n_pass, n_pops;

  typedef struct packed {logic [15:0] pc; logic [15:0] data;} exp_t;
  exp_t sb[$];

  instr_fetch #(.WORD(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_fetch(pc_fetch), .pc_location(pc_location),
    .pc_step(pc_step), .redirect(redirect), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC model: location appears the cycle after pc_fetch; jumps load the target.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_model    <= start_pc;
      pc_location <= 16'h0;
    end else begin
      if (pc_fetch) pc_location <= pc_model;
      if (redirect) pc_model <= jump_tgt;
      else if (pc_step) pc_model <= pc_model + 16'h1;
    end
  end

  // Memory model: ack after ack_wait wait cycles; word content is addr ^ KEY.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else        wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
  end
  assign mem_ack   = mem_req && !ack_block && (wcnt >= ack_wait);
  assign mem_rdata = mem_addr ^ KEY;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic chk_reset(input string name);
    chk(name, {pc_fetch, pc_step, mem_req, mem_addr, instr_valid, instr, instr_pc}, 64'h0);
  endtask

  task automatic push_stream(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      a = base + 16'(i);
      sb.push_back('{pc: a, data: a ^ KEY});
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head must match the next predicted word.
  always @(negedge clk) begin
    if (rst_n && !redirect && instr_valid && instr_ready) begin
      n_pops++;
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_pop: unexpected pop pc=%h instr=%h, none required", instr_pc, instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc", 64'(instr_pc), 64'(e.pc));
        chk("sb_instr", 64'(instr), 64'(e.data));
      end
    end
  end

  initial begin
    int steps, fetches, base;
    n_chk = 0; n_pass = 0; n_pops = 0;
    rst_n = 0; redirect = 0; instr_ready = 0; jump_tgt = 16'h0;
    start_pc = 16'h0010; ack_wait = 0; ack_block = 0;
    push_stream(16'h0010, 8);
    repeat (2) @(posedge clk);
    #4 chk_reset("reset_state");

    // First fetch latency, zero-wait memory
    nxt(); rst_n = 1;
    #3 chk("c0_pc_fetch", 64'(pc_fetch), 64'd1); chk("c0_mem_req", 64'(mem_req), 64'd0);
    steps = int'(pc_step);
    nxt(); #3 chk("c1_pc_fetch", 64'(pc_fetch), 64'd0); chk("c1_mem_req", 64'(mem_req), 64'd0);
    steps += int'(pc_step);
    nxt(); #3 chk("c2_mem_req", 64'(mem_req), 64'd1); chk("c2_mem_addr", 64'(mem_addr), 64'h10);
    chk("c2_pc_step", 64'(pc_step), 64'd1);
    steps += int'(pc_step);
    nxt(); #3 chk("c3_valid", 64'(instr_valid), 64'd1); chk("c3_instr", 64'(instr), 64'hA5A5);
    chk("c3_instr_pc", 64'(instr_pc), 64'h10);
    steps += int'(pc_step);
    chk("first_steps", 64'(steps), 64'd1);

    // Fill to full with decode stalled, then no more fetches
    fetches = 0; steps = 0;
    for (int c = 4; c <= 11; c++) begin nxt(); #3; fetches += int'(pc_fetch); steps += int'(pc_step); end
    chk("fill_fetches", 64'(fetches), 64'd2); chk("fill_steps", 64'(steps), 64'd3);
    fetches = 0; steps = 0;
    for (int c = 12; c <= 17; c++) begin nxt(); #3; fetches += int'(pc_fetch); steps += int'(pc_step); end
    chk("full_fetches", 64'(fetches + steps), 64'd0);
    chk("full_head", 64'({instr_valid, instr_pc}), 64'h1_0010);

    // Redirect flushes a full queue, refill at 0x20
    nxt(); redirect = 1; jump_tgt = 16'h0020; sb.delete(); push_stream(16'h0020, 8);
    #3 chk("redir_no_fetch", 64'(pc_fetch), 64'd0);
    nxt(); redirect = 0;
    #3 chk("flush_valid", 64'(instr_valid), 64'd0); chk("refetch", 64'(pc_fetch), 64'd1);
    fetches = 0;
    for (int c = 20; c <= 33; c++) begin nxt(); #3; if (c >= 31) fetches += int'(pc_fetch); end
    chk("full2_fetches", 64'(fetches), 64'd0);
    chk("full2_head", 64'({instr_valid, instr_pc}), 64'h1_0020);

    // Drain; fetch re-arms the cycle after the first pop
    nxt(); instr_ready = 1;
    #3 chk("c34_fetch", 64'(pc_fetch), 64'd0);
    nxt(); #3 chk("resume_fetch", 64'(pc_fetch), 64'd1);
    nxt(); #3;
    nxt(); #3 chk("c37_head", 64'(instr_pc), 64'h23); chk("c37_step", 64'(pc_step), 64'd1);
    // Push and pop together at one entry: head advances to the wrapped slot
    nxt(); #3 chk("c38_head", 64'({instr_valid, instr_pc, instr}), 64'h1_0024_A591);
    nxt(); ack_wait = 3;
    #3 chk("c39_empty", 64'(instr_valid), 64'd0);

    // Redirect during MEM with 3 wait cycles: drain and discard
    nxt(); redirect = 1; jump_tgt = 16'h0040; sb.delete(); push_stream(16'h0040, 4);
    #3 chk("c40_req", 64'({mem_req, mem_addr}), 64'h1_0025);
    steps = int'(pc_step); fetches = 0;
    for (int c = 41; c <= 43; c++) begin
      nxt(); redirect = 0;
      #3 chk("drain_req", 64'({mem_req, mem_addr}), 64'h1_0025);
      steps += int'(pc_step); fetches += int'(pc_fetch);
    end
    chk("drain_no_step", 64'(steps), 64'd0); chk("drain_no_fetch", 64'(fetches), 64'd0);
    nxt(); #3 chk("post_drain", 64'({pc_fetch, mem_req, instr_valid}), 64'b100);

    // Two entries queued, redirect coincides with ack
    nxt(); ack_wait = 0; instr_ready = 0;
    for (int c = 46; c <= 51; c++) begin nxt(); #3; end
    chk("two_entries_head", 64'({instr_valid, instr_pc}), 64'h1_0040);
    nxt(); redirect = 1; jump_tgt = 16'h0060; sb.delete(); push_stream(16'h0060, 4);
    #3 chk("ack_redir_req", 64'({mem_req, mem_addr}), 64'h1_0042);
    chk("ack_redir_step", 64'(pc_step), 64'd0);
    nxt(); redirect = 0; ack_block = 1; start_pc = 16'h0080;
    #3 chk("ack_redir_flush", 64'({instr_valid, pc_fetch}), 64'b01);

    // Asynchronous reset with a read outstanding
    nxt(); nxt();
    #3 chk("pre_reset_req", 64'({mem_req, mem_addr}), 64'h1_0060);
    #2 rst_n = 0;
    #1 chk_reset("async_reset");
    sb.delete(); push_stream(16'h0080, 8);
    nxt();
    nxt(); rst_n = 1; ack_block = 0; instr_ready = 1; base = n_pops;
    #3 chk("post_reset_fetch", 64'(pc_fetch), 64'd1);
    repeat (11) nxt();
    #3 chk("post_reset_pops", 64'(n_pops - base), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
